// File: rtl/universal_register.sv
// Universal shift/load register: hold, shift right, shift left, parallel load, registered shift-out.
// Optional rotate on shifts when UNIVERSAL_REGISTER_ROTATE_EN is defined (ROT selects it).
module universal_register #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN_L,
  input  logic             SIN_R,
  input  logic             ROT,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_,
  output logic             SOUT_R,
  output logic             SOUT_L
);

  if (WIDTH < 2 || WIDTH > 32) begin : gen_bad_width
    $error("universal_register: WIDTH must be in 2..32");
  end

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeShR   = 2'b01;
  localparam logic [1:0] ModeShL   = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_r_q, sout_r_d;
  logic             sout_l_q, sout_l_d;
  logic             fill_l, fill_r;

`ifdef UNIVERSAL_REGISTER_ROTATE_EN
  // Rotate recirculates the bit leaving the opposite end instead of the serial input.
  assign fill_l = ROT ? q_q[0]       : SIN_L;
  assign fill_r = ROT ? q_q[WIDTH-1] : SIN_R;
`else
  logic unused_rot;
  assign unused_rot = ROT;
  assign fill_l     = SIN_L;
  assign fill_r     = SIN_R;
`endif

  always_comb begin
    q_d      = q_q;
    sout_r_d = sout_r_q;
    sout_l_d = sout_l_q;
    if (EN) begin
      unique case (MODE)
        ModeShR: begin
          q_d      = {fill_l, q_q[WIDTH-1:1]};
          sout_r_d = q_q[0];
        end
        ModeShL: begin
          q_d      = {q_q[WIDTH-2:0], fill_r};
          sout_l_d = q_q[WIDTH-1];
        end
        ModeLoad: q_d = D;
        ModeHold: ;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      q_q      <= RESET_VAL;
      sout_r_q <= 1'b0;
      sout_l_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      sout_r_q <= sout_r_d;
      sout_l_q <= sout_l_d;
    end
  end

  assign Q      = q_q;
  assign Q_     = ~q_q;
  assign SOUT_R = sout_r_q;
  assign SOUT_L = sout_l_q;

endmodule

// File: tb/tb_universal_register.sv
// Directed bench for universal_register: reset, load/hold, shifts, serial-out, rotate, RESET_VAL.
module tb_universal_register;

  logic       clk;
  logic       r;
  logic       en;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin_l, sin_r, rot;
  logic [7:0] q, q_n;
  logic       sout_r, sout_l;
  logic [7:0] q2, q2_n;
  logic       sout_r2, sout_l2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  universal_register #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut (
    .CLK(clk), .R(r), .EN(en), .MODE(mode), .D(d), .SIN_L(sin_l), .SIN_R(sin_r),
    .ROT(rot), .Q(q), .Q_(q_n), .SOUT_R(sout_r), .SOUT_L(sout_l)
  );

  // Second instance: non-zero reset value, permanently in hold mode.
  universal_register #(.WIDTH(8), .RESET_VAL(8'h5A)) u_dut_rv (
    .CLK(clk), .R(r), .EN(1'b1), .MODE(2'b00), .D(8'hFF), .SIN_L(1'b1), .SIN_R(1'b1),
    .ROT(1'b0), .Q(q2), .Q_(q2_n), .SOUT_R(sout_r2), .SOUT_L(sout_l2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic e, input logic [1:0] m, input logic [7:0] dv,
                    input logic sl, input logic sr, input logic rt);
    en = e; mode = m; d = dv; sin_l = sl; sin_r = sr; rot = rt;
    tick();
  endtask

  initial begin
    r = 1'b1; en = 1'b0; mode = 2'b00; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0; rot = 1'b0;
    #1 r = 1'b0;
    #1;
    check("rst_q", q, 8'h00);
    check("rst_qn", q_n, 8'hFF);
    check("rst_sout_r", sout_r, 1'b0);
    check("rst_sout_l", sout_l, 1'b0);
    check("rv_rst_q", q2, 8'h5A);
    check("rv_rst_qn", q2_n, 8'hA5);
    tick();
    r = 1'b1;

    // RESET_VAL instance holds through two edges after release
    tick();
    check("rv_q_e1", q2, 8'h5A);
    check("rv_qn_e1", q2_n, 8'hA5);
    tick();
    check("rv_q_e2", q2, 8'h5A);
    check("rv_qn_e2", q2_n, 8'hA5);

    op(1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0);
    check("load_q", q, 8'h3C);
    check("load_qn", q_n, 8'hC3);
    check("load_sout_r", sout_r, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0);
      check("en0_hold_q", q, 8'h3C);
    end
    op(1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 1'b0);
    check("mode00_hold_q", q, 8'h3C);

    op(1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
    op(1'b1, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0);
    check("shr1_q", q, 8'h40);
    check("shr1_sout_r", sout_r, 1'b1);
    check("shr1_sout_l", sout_l, 1'b0);
    op(1'b1, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0);
    check("shr2_q", q, 8'h20);
    check("shr2_sout_r", sout_r, 1'b0);

    op(1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
    op(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
    check("shl_q", q, 8'h03);
    check("shl_sout_l", sout_l, 1'b1);
    check("shl_sout_r_held", sout_r, 1'b0);
    op(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
    check("shr_sin1_q", q, 8'h81);
    check("shr_sin1_sout_r", sout_r, 1'b1);
    check("shr_sin1_sout_l_held", sout_l, 1'b1);
    op(1'b0, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    check("en0_q", q, 8'h81);
    check("en0_sout_r", sout_r, 1'b1);
    check("en0_sout_l", sout_l, 1'b1);
    op(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("load_a5_q", q, 8'hA5);
    check("load_sout_held", {sout_r, sout_l}, 2'b11);

    // Mid-cycle asynchronous reset
    #3 r = 1'b0;
    #1;
    check("async_rst_q", q, 8'h00);
    check("async_rst_qn", q_n, 8'hFF);
    check("async_rst_sout", {sout_r, sout_l}, 2'b00);
    op(1'b1, 2'b11, 8'hFF, 1'b1, 1'b1, 1'b0);
    check("rst_priority_q", q, 8'h00);
    check("rst_priority_qn", q_n, 8'hFF);
    r = 1'b1;
    op(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("first_edge_q", q, 8'hFF);

    // Rotate behaviour
    op(1'b1, 2'b11, 8'h01, 1'b0, 1'b0, 1'b0);
    op(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef UNIVERSAL_REGISTER_ROTATE_EN
    check("rotr_q", q, 8'h80);
`else
    check("rotr_q", q, 8'h00);
`endif
    check("rotr_sout_r", sout_r, 1'b1);
    op(1'b1, 2'b11, 8'h80, 1'b0, 1'b0, 1'b0);
    op(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef UNIVERSAL_REGISTER_ROTATE_EN
    check("rotl_q", q, 8'h01);
`else
    check("rotl_q", q, 8'h00);
`endif
    check("rotl_sout_l", sout_l, 1'b1);
    op(1'b1, 2'b11, 8'h01, 1'b0, 1'b0, 1'b0);
    op(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rot0_q", q, 8'h00);
    check("qn_tracks", q_n, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 SHALL provide parameter RESET_VAL, default 0, WIDTH-bit value loaded on reset.
REQ-003 SHALL provide port CLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL provide port R  input  1  reset; asynchronous, active-low.
REQ-005 SHALL provide port EN  input  1  update enable; 0 holds state regardless of MODE.
REQ-006 SHALL provide port MODE  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 SHALL provide port D  input  WIDTH  parallel load data.
REQ-008 SHALL provide port SIN_L  input  1  serial in, enters MSB on shift right.
REQ-009 SHALL provide port SIN_R  input  1  serial in, enters LSB on shift left.
REQ-010 SHALL provide port ROT  input  1  rotate select; used only when UNIVERSAL_REGISTER_ROTATE_EN is defined.
REQ-011 SHALL provide port Q  output  WIDTH  register contents.
REQ-012 SHALL provide port Q_  output  WIDTH  bitwise complement of Q, always.
REQ-013 SHALL provide port SOUT_R  output  1  bit shifted out on the last shift right (registered).
REQ-014 SHALL provide port SOUT_L  output  1  bit shifted out on the last shift left (registered).

Function
REQ-015 SHALL, on a rising CLK edge with R=1 and EN=1, update Q per MODE; with EN=0, hold Q, SOUT_R and SOUT_L.
REQ-016 SHALL, for MODE=11, set Q to D; SOUT_R and SOUT_L held.
REQ-017 SHALL, for MODE=01, set Q to {SIN_L, Q[WIDTH-1:1]} and SOUT_R to old Q[0]; SOUT_L held.
REQ-018 SHALL, for MODE=10, set Q to {Q[WIDTH-2:0], SIN_R} and SOUT_L to old Q[WIDTH-1]; SOUT_R held.
REQ-019 SHALL, for MODE=00, hold all state even with EN=1.
REQ-020 SHALL exhibit one-cycle latency: the result of an operation is visible on Q after the same edge that samples it.
REQ-021 SHALL keep Q_ equal to ~Q combinationally at all times, including during and immediately after reset.
REQ-022 SHALL treat bit shifts as non-arithmetic; no sign extension, no wrap except under REQ-029.

Reset
REQ-023 SHALL, while R=0, force Q to RESET_VAL, Q_ to ~RESET_VAL, SOUT_R and SOUT_L to 0, independent of CLK.
REQ-024 SHALL apply reset immediately on R falling, aborting any operation in the same cycle; no partial update occurs.
REQ-025 SHALL, on the first rising CLK edge after R rises, perform the operation selected by EN/MODE normally.
REQ-026 SHALL give reset priority over EN, MODE, D and serial inputs when asserted coincident with a clock edge.

Configuration
REQ-027 SHALL support macro UNIVERSAL_REGISTER_ROTATE_EN selecting rotate capability.
REQ-028 SHALL, without the macro, ignore ROT entirely; shifts always take SIN_L/SIN_R.
REQ-029 SHALL, with the macro and ROT=1, replace SIN_L with old Q[0] on shift right and SIN_R with old Q[WIDTH-1] on shift left; SOUT_R/SOUT_L update as in REQ-017/018.
REQ-030 SHALL, with the macro and ROT=0, behave identically to the macro-less build.

Verification (WIDTH=8, RESET_VAL=8'h00 unless stated)
REQ-031 SHALL verify reset: R=0 mid-cycle with Q=8'hA5 -> Q=8'h00, Q_=8'hFF, SOUT_R=SOUT_L=0 before next edge.
REQ-032 SHALL verify load/hold: EN=1, MODE=11, D=8'h3C, one edge -> Q=8'h3C; then EN=0, MODE=11, D=8'hFF, three edges -> Q stays 8'h3C.
REQ-033 SHALL verify shift right: Q=8'h81, MODE=01, SIN_L=0, one edge -> Q=8'h40, SOUT_R=1; second edge -> Q=8'h20, SOUT_R=0.
REQ-034 SHALL verify shift left: Q=8'h81, MODE=10, SIN_R=1, one edge -> Q=8'h03, SOUT_L=1.
REQ-035 SHALL verify rotate (macro defined): Q=8'h01, MODE=01, ROT=1, SIN_L=0, one edge -> Q=8'h80, SOUT_R=1; macro undefined, same stimulus -> Q=8'h00.
REQ-036 SHALL verify RESET_VAL=8'h5A: release R, MODE=00, EN=1, two edges -> Q=8'h5A, Q_=8'hA5 throughout.
